uart_rx: RTL
============

Name: uart_rx

Overview:
Serial receiver paired with uart_tx. It recovers 8N1-style frames from the asynchronous rx line and presents each received word on a parallel bus with a one-cycle valid strobe. The block sits directly downstream of a uart_tx line, either off-chip or on-chip for loopback. Its frame format matches uart_tx exactly: a start bit of 0, W_DATA data bits LSB first, and one stop bit of 1.

Parameters:
- CLK_FREQUENCY, 50_000_000, system clock frequency in Hz.
- BITRATE, 115_200, line rate in bit/s. BIT_PERIOD = CLK_FREQUENCY / BITRATE, using integer division; BIT_PERIOD >= 4 is required.
- W_DATA, 8, number of data bits per frame.

Ports:
- clk  input  1  system clock; all logic on posedge.
- arstn  input  1  reset, synchronous, active-low. Sampled only on posedge clk.
- rx  input  1  asynchronous serial line; idles at 1.
- data  output  W_DATA  last correctly received word; holds until the next good frame.
- rx_valid  output  1  one-cycle pulse; data is new on this cycle.
- frame_err  output  1  one-cycle pulse; stop bit was sampled as 0.
- rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (arstn=0 at posedge): state=IDLE, data=0, rx_valid=0, frame_err=0, rx_busy=0, counters=0, synchronizer flops=1.
- rx passes through a 2-flop synchronizer to give rx_s; all decisions use rx_s. This adds 2 cycles of input latency.
- Counters:
  - period_cnt is $clog2(BIT_PERIOD) wide. It increments every cycle in non-IDLE states and clears on every state change and at BIT_PERIOD-1.
  - bit_cnt is $clog2(W_DATA+1) wide.
- IDLE: when rx_s=0, go to START with period_cnt=0.
- START: at period_cnt == BIT_PERIOD/2 - 1, sample rx_s (mid start bit).
  - If 0: go to DATA with period_cnt=0, bit_cnt=0.
  - If 1 (glitch or false start): go to IDLE with no outputs.
- DATA: at period_cnt == BIT_PERIOD-1 (mid-bit), shift rx_s into the MSB of the shift register (right shift) and increment bit_cnt. When bit_cnt reaches W_DATA-1 at that sample, go to STOP.
- STOP: at period_cnt == BIT_PERIOD-1, sample rx_s.
  - If 1: next cycle data <= shift register and rx_valid=1; go to IDLE.
  - If 0: next cycle frame_err=1 and data is unchanged; go to BREAK.
- BREAK: wait until rx_s=1, then go to IDLE. This prevents a held-low line from being decoded as 0x00 frames.
- Return to IDLE occurs at the stop-bit midpoint, so a back-to-back next start bit (no idle gap) is detected. Half a bit of slack remains.
- Latency: rx_valid asserts 2 (synchronizer) + 1 cycles after the stop-bit mid-sample.
- rx_valid and frame_err are never high together. Neither ever lasts more than one cycle.
- Reset mid-frame: the frame is discarded, there is no pulse, and reset values apply the next cycle.
- There is no flow control. A consumer must take data within one frame time, or the word is overwritten by the next good frame.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, STOP, BREAK}.
  - Function bit_period(clk_freq, bitrate), shared with uart_tx.
  - Constants START_BIT=0 and STOP_BIT=1.
- Sub-module uart_sync: 2-flop synchronizer, reset value 1. It is reusable for tx_ready in uart_tx.

Test Plan:
Common setup: CLK_FREQUENCY=50_000_000, BITRATE=5_000_000, giving BIT_PERIOD=10, with W_DATA=8.
1. Drive frame 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1; 10 cycles each) -> exactly one rx_valid with data=0xA5, frame_err never high, rx_busy low after.
2. Pulse rx low for 3 cycles then high -> START aborts, no rx_valid or frame_err, state back to IDLE.
3. Drive frame 0x3C with the stop bit forced to 0, then hold the line low for 50 cycles -> one frame_err pulse, data keeps its prior value, no further pulses until rx returns high.
4. Send 0x00 then 0xFF back-to-back with no idle gap -> two rx_valid pulses 100 cycles apart, with data=0x00 then data=0xFF.
5. Assert arstn=0 for 1 cycle during data bit 4 of a frame -> no pulses for that frame; the next clean frame 0x81 is received correctly.
6. Loopback: uart_tx (W_PACKAGE=10) drives rx with 256 sequential bytes -> every byte received in order, zero frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive/transmit pair.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int unsigned bit_period(int unsigned clk_freq, int unsigned bitrate);
    return clk_freq / bitrate;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line in, received word out; master is the receiver, slave the line driver/consumer.
interface uart_rx_if #(
  parameter int unsigned W_DATA = 8
);
  logic              rx;
  logic [W_DATA-1:0] data;
  logic              rx_valid;
  logic              frame_err;
  logic              rx_busy;

  modport master (input rx, output data, output rx_valid, output frame_err, output rx_busy);
  modport slave  (output rx, input data, input rx_valid, input frame_err, input rx_busy);
endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer; resets to 1 so an idle serial line looks idle out of reset.
module uart_sync (
  input  logic clk,
  input  logic arstn,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;

  always_ff @(posedge clk) begin
    if (!arstn) ff_q <= 2'b11;
    else        ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];
endmodule

// File: rtl/uart_rx.sv
// 8N1-style serial receiver: start-bit qualification, mid-bit sampling, framing-error detection.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY = 50_000_000,
  parameter int unsigned BITRATE       = 115_200,
  parameter int unsigned W_DATA        = 8
) (
  input logic      clk,
  input logic      arstn,
  uart_rx_if.master bus
);
  localparam int unsigned BIT_PERIOD = bit_period(CLK_FREQUENCY, BITRATE);
  localparam int unsigned W_PERIOD   = $clog2(BIT_PERIOD);
  localparam int unsigned W_BIT      = $clog2(W_DATA + 1);

  localparam logic [W_PERIOD-1:0] LAST_TICK = W_PERIOD'(BIT_PERIOD - 1);
  localparam logic [W_PERIOD-1:0] MID_TICK  = W_PERIOD'(BIT_PERIOD / 2 - 1);
  localparam logic [W_BIT-1:0]    LAST_BIT  = W_BIT'(W_DATA - 1);

  logic rx_s;

  rx_state_t           state_q, state_d;
  logic [W_PERIOD-1:0] period_cnt_q, period_cnt_d;
  logic [W_BIT-1:0]    bit_cnt_q, bit_cnt_d;
  logic [W_DATA-1:0]   shift_q, shift_d;
  logic [W_DATA-1:0]   data_q, data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                tick;

  uart_sync u_sync (
    .clk  (clk),
    .arstn(arstn),
    .d_i  (bus.rx),
    .q_o  (rx_s)
  );

  assign tick = (period_cnt_q == LAST_TICK);

  always_comb begin
    state_d      = state_q;
    period_cnt_d = (state_q == IDLE || tick) ? '0 : period_cnt_q + W_PERIOD'(1);
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_d       = data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_s == START_BIT) state_d = START;
      end
      START: begin
        if (period_cnt_q == MID_TICK) begin
          if (rx_s == START_BIT) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d   = {rx_s, shift_q[W_DATA-1:1]};
          bit_cnt_d = bit_cnt_q + W_BIT'(1);
          if (bit_cnt_q == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        // Leave at the stop-bit midpoint so a gapless next start bit is still caught.
        if (tick) begin
          if (rx_s == STOP_BIT) begin
            data_d     = shift_q;
            rx_valid_d = 1'b1;
            state_d    = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s == STOP_BIT) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) period_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_q      <= IDLE;
      period_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.data      = data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.rx_busy   = (state_q != IDLE);
endmodule
